counter_cmd_arbiter: RTL and testbench

Shares one saturating up/down counter (en/dir/load/data/out, range 0..MAX_VAL) between two requesters. Each requester issues a command: LOAD a value, or step UP/DOWN N times. Commands are arbitrated round-robin and sequenced into counter control pulses. A shadow copy of the count enforces the saturation bounds and is compared against the counter output to flag mismatches.

---
 rtl/counter_cmd_arbiter_if.sv | 36 +++
 rtl/counter_cmd_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_counter_cmd_arbiter.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/counter_cmd_arbiter_if.sv
// Bus between counter_cmd_arbiter and its two requesters plus the shared counter.
// master: requester/counter side; slave: the arbiter.
interface counter_cmd_arbiter_if #(
   parameter int unsigned WIDTH = 4
);
   logic             req0;
   logic [1:0]       cmd0;
   logic [WIDTH-1:0] arg0;
   logic             gnt0;
   logic             done0;
   logic             req1;
   logic [1:0]       cmd1;
   logic [WIDTH-1:0] arg1;
   logic             gnt1;
   logic             done1;
   logic             cnt_en;
   logic             cnt_dir;
   logic             cnt_load;
   logic [WIDTH-1:0] cnt_data;
   logic [WIDTH-1:0] cnt_out;
   logic             sat;
   logic             busy;
   logic             err;

   modport master (
      output req0, cmd0, arg0, req1, cmd1, arg1, cnt_out,
      input  gnt0, done0, gnt1, done1, cnt_en, cnt_dir, cnt_load, cnt_data,
             sat, busy, err
   );

   modport slave (
      input  req0, cmd0, arg0, req1, cmd1, arg1, cnt_out,
      output gnt0, done0, gnt1, done1, cnt_en, cnt_dir, cnt_load, cnt_data,
             sat, busy, err
   );
endinterface

// File: rtl/counter_cmd_arbiter.sv
// Two-requester arbiter sequencing LOAD/UP/DOWN commands onto a saturating counter,
// with a shadow count for bound enforcement and mismatch detection.
// Optional ARB_FIXED_PRIO_EN: requester 0 always wins ties (default is round-robin).
module counter_cmd_arbiter #(
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned MAX_VAL = 12
) (
   input logic                  clk,
   input logic                  rst,
   counter_cmd_arbiter_if.slave bus
);

   localparam logic [WIDTH-1:0] MAX_W    = WIDTH'(MAX_VAL);
   localparam logic [1:0]       CMD_LOAD = 2'b00;
   localparam logic [1:0]       CMD_UP   = 2'b01;
   localparam logic [1:0]       CMD_DOWN = 2'b10;

   typedef enum logic [1:0] {S_IDLE, S_GRANT, S_RUN, S_DONE} state_e;

   state_e           state_q, state_d;
   logic             owner_q, owner_d;
   logic             last_q, last_d;
   logic [1:0]       cmd_q, cmd_d;
   logic [WIDTH-1:0] arg_q, arg_d;
   logic [WIDTH-1:0] load_val_q, load_val_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] shadow_q, shadow_d;
   logic             sat_flag_q, sat_flag_d;
   logic             err_q, err_d;
   logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
   logic             done0_q, done0_d, done1_q, done1_d;
   logic             cnt_en_q, cnt_en_d, cnt_dir_q, cnt_dir_d, cnt_load_q, cnt_load_d;
   logic [WIDTH-1:0] cnt_data_q, cnt_data_d;
   logic             sat_q, sat_d;
   logic             busy_q, busy_d;
   logic             pick;

   function automatic logic at_bound(input logic [1:0] cmd, input logic [WIDTH-1:0] val);
      return (cmd == CMD_UP) ? (val == MAX_W) : (val == '0);
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         owner_q    <= 1'b0;
         last_q     <= 1'b1;
         cmd_q      <= '0;
         arg_q      <= '0;
         load_val_q <= '0;
         rem_q      <= '0;
         shadow_q   <= '0;
         sat_flag_q <= 1'b0;
         err_q      <= 1'b0;
         gnt0_q     <= 1'b0;
         gnt1_q     <= 1'b0;
         done0_q    <= 1'b0;
         done1_q    <= 1'b0;
         cnt_en_q   <= 1'b0;
         cnt_dir_q  <= 1'b0;
         cnt_load_q <= 1'b0;
         cnt_data_q <= '0;
         sat_q      <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         last_q     <= last_d;
         cmd_q      <= cmd_d;
         arg_q      <= arg_d;
         load_val_q <= load_val_d;
         rem_q      <= rem_d;
         shadow_q   <= shadow_d;
         sat_flag_q <= sat_flag_d;
         err_q      <= err_d;
         gnt0_q     <= gnt0_d;
         gnt1_q     <= gnt1_d;
         done0_q    <= done0_d;
         done1_q    <= done1_d;
         cnt_en_q   <= cnt_en_d;
         cnt_dir_q  <= cnt_dir_d;
         cnt_load_q <= cnt_load_d;
         cnt_data_q <= cnt_data_d;
         sat_q      <= sat_d;
         busy_q     <= busy_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      last_d     = last_q;
      cmd_d      = cmd_q;
      arg_d      = arg_q;
      load_val_d = load_val_q;
      rem_d      = rem_q;
      shadow_d   = shadow_q;
      sat_flag_d = sat_flag_q;
      pick       = 1'b0;

`ifdef ARB_FIXED_PRIO_EN
      pick = !bus.req0;
`else
      pick = (bus.req0 && bus.req1) ? !last_q : !bus.req0;
`endif

      case (state_q)
         S_IDLE: begin
            if (bus.req0 || bus.req1) begin
               owner_d    = pick;
               cmd_d      = pick ? bus.cmd1 : bus.cmd0;
               arg_d      = pick ? bus.arg1 : bus.arg0;
               sat_flag_d = 1'b0;
               state_d    = S_GRANT;
            end
         end
         S_GRANT: begin
            last_d     = owner_q;
            load_val_d = (arg_q > MAX_W) ? MAX_W : arg_q;
            case (cmd_q)
               CMD_UP, CMD_DOWN: rem_d = arg_q;
               CMD_LOAD:         rem_d = WIDTH'(1);
               default:          rem_d = '0;
            endcase
            state_d = S_RUN;
         end
         S_RUN: begin
            state_d = S_DONE;
            case (cmd_q)
               CMD_LOAD: begin
                  shadow_d = load_val_q;
                  rem_d    = '0;
               end
               CMD_UP, CMD_DOWN: begin
                  if (rem_q != '0) begin
                     if (at_bound(cmd_q, shadow_q)) begin
                        sat_flag_d = 1'b1;
                     end else begin
                        shadow_d = (cmd_q == CMD_UP) ? shadow_q + WIDTH'(1)
                                                     : shadow_q - WIDTH'(1);
                        rem_d    = rem_q - WIDTH'(1);
                        // Stop on exhaustion; flag sat only if steps were cut short.
                        if (rem_d != '0) begin
                           if (at_bound(cmd_q, shadow_d)) sat_flag_d = 1'b1;
                           else                           state_d    = S_RUN;
                        end
                     end
                  end
               end
               default: ;
            endcase
         end
         default: state_d = S_IDLE;
      endcase

      err_d = err_q | (((state_q == S_IDLE) || (state_q == S_DONE)) &&
                       (bus.cnt_out != shadow_q));

      // Registered outputs are decoded from the upcoming state so they align with it.
      gnt0_d     = (state_d == S_GRANT) && !owner_d;
      gnt1_d     = (state_d == S_GRANT) &&  owner_d;
      done0_d    = (state_d == S_DONE)  && !owner_d;
      done1_d    = (state_d == S_DONE)  &&  owner_d;
      sat_d      = (state_d == S_DONE)  && sat_flag_d;
      busy_d     = (state_d != S_IDLE);
      cnt_en_d   = 1'b0;
      cnt_dir_d  = 1'b0;
      cnt_load_d = 1'b0;
      cnt_data_d = '0;
      if (state_d == S_RUN) begin
         case (cmd_d)
            CMD_LOAD: begin
               cnt_en_d   = 1'b1;
               cnt_load_d = 1'b1;
               cnt_data_d = load_val_d;
            end
            CMD_UP, CMD_DOWN: begin
               cnt_en_d  = (rem_d != '0) && !at_bound(cmd_d, shadow_d);
               cnt_dir_d = cnt_en_d && (cmd_d == CMD_UP);
            end
            default: ;
         endcase
      end
   end

   assign bus.gnt0     = gnt0_q;
   assign bus.gnt1     = gnt1_q;
   assign bus.done0    = done0_q;
   assign bus.done1    = done1_q;
   assign bus.cnt_en   = cnt_en_q;
   assign bus.cnt_dir  = cnt_dir_q;
   assign bus.cnt_load = cnt_load_q;
   assign bus.cnt_data = cnt_data_q;
   assign bus.sat      = sat_q;
   assign bus.busy     = busy_q;
   assign bus.err      = err_q;

endmodule

// File: tb/tb_counter_cmd_arbiter.sv
// Bench for counter_cmd_arbiter: command table with scoreboard, plus arbitration,
// shadow-mismatch and reset-abort sequences. A behavioural counter closes the loop.
module tb_counter_cmd_arbiter;

   localparam logic [1:0] C_LOAD = 2'b00;
   localparam logic [1:0] C_UP   = 2'b01;
   localparam logic [1:0] C_DOWN = 2'b10;
   localparam logic [1:0] C_NOP  = 2'b11;

   typedef struct {
      logic       who;
      logic [1:0] cmd;
      logic [3:0] arg;
      int         pulses;
      logic       sat;
      logic [3:0] fin;
   } vec_t;

   typedef struct {
      logic       owner;
      logic [1:0] cmd;
      int         pulses;
      logic       sat;
      logic [3:0] fin;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       force_en = 1'b0;
   logic [3:0] force_val = '0;
   logic [3:0] cnt_model;
   int         cyc = 0;
   int         total = 0;
   int         bad = 0;
   int         pulses = 0;
   int         gnt_cyc = 0;
   logic       last_own = 1'b1;
   exp_t       sbq[$];
   vec_t       vecs[12];

   counter_cmd_arbiter_if #(.WIDTH(4)) bus ();

   counter_cmd_arbiter #(.WIDTH(4), .MAX_VAL(12)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk or negedge rst) begin
      if (!rst)                cnt_model <= '0;
      else if (bus.cnt_en) begin
         if (bus.cnt_load)     cnt_model <= bus.cnt_data;
         else if (bus.cnt_dir) cnt_model <= cnt_model + 4'd1;
         else                  cnt_model <= cnt_model - 4'd1;
      end
   end
   assign bus.cnt_out = force_en ? force_val : cnt_model;

   task automatic chk(input string name, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d (cycle %0d)", name, got, want, cyc);
      end
   endtask

   function automatic int outs();
      return int'({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.cnt_en, bus.cnt_dir,
                   bus.cnt_load, bus.cnt_data, bus.sat, bus.busy, bus.err});
   endfunction

   // Scoreboard monitor: checks each pulse and each completion against the queue head.
   always @(negedge clk) begin
      if (rst) begin
         if (bus.gnt0 || bus.gnt1) begin
            gnt_cyc = cyc;
            pulses  = 0;
            chk("gnt_onehot", int'(bus.gnt0 && bus.gnt1), 0);
            if (sbq.size() > 0) chk("gnt_owner", int'(bus.gnt1), int'(sbq[0].owner));
         end
         if (bus.cnt_en) begin
            pulses++;
            if (sbq.size() > 0) begin
               chk("pulse_load", int'(bus.cnt_load), int'(sbq[0].cmd == C_LOAD));
               chk("pulse_dir", int'(bus.cnt_dir), int'(sbq[0].cmd == C_UP));
               if (sbq[0].cmd == C_LOAD) chk("pulse_data", int'(bus.cnt_data), int'(sbq[0].fin));
            end
         end
         if (bus.done0 || bus.done1) begin
            if (sbq.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               exp_t e;
               e = sbq.pop_front();
               chk("done_owner", int'(bus.done1), int'(e.owner));
               chk("done_pulses", pulses, e.pulses);
               chk("done_sat", int'(bus.sat), int'(e.sat));
               chk("done_count", int'(bus.cnt_out), int'(e.fin));
               chk("done_latency", cyc - gnt_cyc, ((e.pulses == 0) ? 1 : e.pulses) + 1);
               chk("done_err", int'(bus.err), 0);
            end
         end
      end
   end

   task automatic issue(input logic both, input logic who, input logic [1:0] cmd,
                        input logic [3:0] arg, input int np, input logic s,
                        input logic [3:0] fin);
      exp_t e;
      logic own;
      bit   got;
`ifdef ARB_FIXED_PRIO_EN
      own = both ? 1'b0 : who;
`else
      own = both ? !last_own : who;
`endif
      @(negedge clk);
      chk("idle_busy", int'(bus.busy), 0);
      if (both || !who) begin bus.req0 = 1'b1; bus.cmd0 = cmd; bus.arg0 = arg; end
      if (both ||  who) begin bus.req1 = 1'b1; bus.cmd1 = cmd; bus.arg1 = arg; end
      e = '{owner: own, cmd: cmd, pulses: np, sat: s, fin: fin};
      sbq.push_back(e);
      @(negedge clk);
      chk("gnt_latency", int'(own ? bus.gnt1 : bus.gnt0), 1);
      chk("gnt_busy", int'(bus.busy), 1);
      last_own = own;
      bus.cmd0 = 2'($urandom); bus.arg0 = 4'($urandom);
      bus.cmd1 = 2'($urandom); bus.arg1 = 4'($urandom);
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (bus.done0 || bus.done1) got = 1'b1;
      end
      if (!got) begin
         chk("done_timeout", 0, 1);
         if (sbq.size() > 0) void'(sbq.pop_front());
      end
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{1'b0, C_LOAD, 4'd5,  1, 1'b0, 4'd5};
      vecs[1]  = '{1'b0, C_UP,   4'd3,  3, 1'b0, 4'd8};
      vecs[2]  = '{1'b1, C_UP,   4'd2,  2, 1'b0, 4'd10};
      vecs[3]  = '{1'b1, C_UP,   4'd6,  2, 1'b1, 4'd12};
      vecs[4]  = '{1'b1, C_UP,   4'd1,  0, 1'b1, 4'd12};
      vecs[5]  = '{1'b0, C_LOAD, 4'd15, 1, 1'b0, 4'd12};
      vecs[6]  = '{1'b0, C_DOWN, 4'd0,  0, 1'b0, 4'd12};
      vecs[7]  = '{1'b1, C_NOP,  4'd7,  0, 1'b0, 4'd12};
      vecs[8]  = '{1'b0, C_DOWN, 4'd5,  5, 1'b0, 4'd7};
      vecs[9]  = '{1'b1, C_DOWN, 4'd15, 7, 1'b1, 4'd0};
      vecs[10] = '{1'b0, C_DOWN, 4'd1,  0, 1'b1, 4'd0};
      vecs[11] = '{1'b1, C_LOAD, 4'd4,  1, 1'b0, 4'd4};

      bus.req0 = 1'b0; bus.cmd0 = C_NOP; bus.arg0 = '0;
      bus.req1 = 1'b0; bus.cmd1 = C_NOP; bus.arg1 = '0;

      repeat (2) @(negedge clk);
      chk("reset_outputs", outs(), 0);
      rst = 1'b1;
      @(negedge clk);
      chk("post_reset_outputs", outs(), 0);

      foreach (vecs[i])
         issue(1'b0, vecs[i].who, vecs[i].cmd, vecs[i].arg,
               vecs[i].pulses, vecs[i].sat, vecs[i].fin);

      // Simultaneous requests; both withdraw after the winner completes.
      for (int r = 0; r < 4; r++) issue(1'b1, 1'b0, C_NOP, 4'd0, 0, 1'b0, 4'd4);

      // Shadow mismatch in IDLE sets a sticky error.
      @(negedge clk);
      chk("err_clear", int'(bus.err), 0);
      force_en = 1'b1; force_val = 4'd3;
      repeat (2) @(negedge clk);
      chk("err_set", int'(bus.err), 1);
      force_en = 1'b0;
      repeat (3) @(negedge clk);
      chk("err_sticky", int'(bus.err), 1);

      // Reset in the middle of a long UP command.
      bus.req0 = 1'b1; bus.cmd0 = C_UP; bus.arg0 = 4'd8;
      @(negedge clk);
      chk("abort_gnt", int'(bus.gnt0), 1);
      repeat (2) @(negedge clk);
      chk("abort_running", int'(bus.cnt_en), 1);
      #2 rst = 1'b0;
      bus.req0 = 1'b0;
      #1 chk("abort_outputs", outs(), 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("abort_no_done", int'(bus.done0 || bus.done1), 0);
      end
      #2 rst = 1'b1;
      @(negedge clk);
      chk("abort_idle", outs(), 0);
      last_own = 1'b1;
      issue(1'b0, 1'b1, C_LOAD, 4'd9, 1, 1'b0, 4'd9);
      issue(1'b1, 1'b0, C_UP,   4'd2, 2, 1'b0, 4'd11);

      repeat (2) @(negedge clk);
      chk("queue_drained", sbq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
